// File: rtl/video_vblank_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : video_sched_pkg
//  Description : Shared types and default widths for the vertical-blanking
//                video write scheduler.
//                  state_t  - scheduler state (IDLE, ARMED, DRAIN)
//                  entry_t  - one queued write {addr, data} at default widths
//  Revision    : 1.0 - initial release
// ============================================================================
package video_sched_pkg;

    localparam int c_default_depth_log2 = 6;
    localparam int c_default_aw         = 21;
    localparam int c_default_dw         = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Layout of one queue word; the FIFO stores it as {addr, data}.
    typedef struct packed {
        logic [c_default_aw-1:0] addr;
        logic [c_default_dw-1:0] data;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/video_vblank_write_scheduler_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vsched_fifo
//  Description : Synchronous first-word-fall-through FIFO. head always shows
//                the oldest entry while empty is low. A push while full is
//                accepted only when a pop happens in the same cycle;
//                otherwise it is dropped and push_drop is raised.
//  Ports       : clk, reset         - clock, synchronous active-high reset
//                push, push_data    - write side
//                pop, head          - read side (pop ignored when empty)
//                full, empty        - status
//                push_drop          - this cycle's push was refused
//                count, count_next  - occupancy now / after this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module vsched_fifo #(
    parameter int W          = 53,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [W-1:0]          push_data,
    input  logic                  pop,
    output logic [W-1:0]          head,
    output logic                  full,
    output logic                  empty,
    output logic                  push_drop,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   count_next
);

    localparam int                  c_depth    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_cnt_one  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0] c_cnt_full = (DEPTH_LOG2+1)'(c_depth);
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one = DEPTH_LOG2'(1);

    logic [W-1:0]            mem_q [c_depth];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q,  count_d;
    logic                    w_do_push;
    logic                    w_do_pop;

    always_comb begin
        full      = (count_q == c_cnt_full);
        empty     = (count_q == '0);
        w_do_pop  = pop && !empty;
        // A pop frees a slot in the same cycle, so a full FIFO can still take a push.
        w_do_push = push && (!full || w_do_pop);
        push_drop = push && !w_do_push;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_push) begin
            wr_ptr_d = wr_ptr_q + c_ptr_one;
        end
        if (w_do_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_one;
        end
        if (w_do_push && !w_do_pop) begin
            count_d = count_q + c_cnt_one;
        end else if (!w_do_push && w_do_pop) begin
            count_d = count_q - c_cnt_one;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule
`default_nettype wire

// File: rtl/video_vblank_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : video_vblank_write_scheduler
//  Description : Queues host writes to the video I/O space and replays a
//                committed batch onto the video bus only during vertical
//                blanking (frame_end .. frame_start). A direct write port
//                shares the bus and is blocked only while draining.
//  Ports       : clk, reset                 - clock, sync active-high reset
//                frame_start, frame_end     - frame timing pulses
//                q_wr, q_addr, q_data       - queue push
//                commit, clr_ovf            - arm replay / clear overflow
//                d_valid, d_addr, d_data,
//                d_ready                    - direct write handshake
//                video_cs, video_wr,
//                video_addr, video_wr_data  - registered video bus
//                q_count, busy, done,
//                overflow                   - status
//  Revision    : 1.0 - initial release
// ============================================================================
module video_vblank_write_scheduler
    import video_sched_pkg::*;
#(
    parameter int DEPTH_LOG2 = c_default_depth_log2,
    parameter int AW         = c_default_aw,
    parameter int DW         = c_default_dw
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic                 frame_end,
    input  logic                 q_wr,
    input  logic [AW-1:0]        q_addr,
    input  logic [DW-1:0]        q_data,
    input  logic                 commit,
    input  logic                 clr_ovf,
    input  logic                 d_valid,
    input  logic [AW-1:0]        d_addr,
    input  logic [DW-1:0]        d_data,
    output logic                 d_ready,
    output logic                 video_cs,
    output logic                 video_wr,
    output logic [AW-1:0]        video_addr,
    output logic [DW-1:0]        video_wr_data,
    output logic [DEPTH_LOG2:0]  q_count,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);

    localparam logic [DEPTH_LOG2:0] c_cnt_one = (DEPTH_LOG2+1)'(1);

    logic [AW+DW-1:0]     w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;
    logic [DEPTH_LOG2:0]  w_count;
    logic [DEPTH_LOG2:0]  w_count_next;
    logic                 w_pop;
    logic                 w_direct;

    state_t               state_q,     state_d;
    logic [DEPTH_LOG2:0]  remaining_q, remaining_d;
    logic                 overflow_q,  overflow_d;
    logic                 done_q,      done_d;
    logic                 d_ready_q,   d_ready_d;
    logic                 bus_vld_q,   bus_vld_d;
    logic [AW-1:0]        bus_addr_q,  bus_addr_d;
    logic [DW-1:0]        bus_data_q,  bus_data_d;

    vsched_fifo #(
        .W          (AW + DW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (q_wr),
        .push_data  ({q_addr, q_data}),
        .pop        (w_pop),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty),
        .push_drop  (w_drop),
        .count      (w_count),
        .count_next (w_count_next)
    );

    always_comb begin
        // frame_start closes the blanking window: no pop in that cycle.
        w_pop    = (state_q == DRAIN) && (remaining_q != '0) && !frame_start && !w_empty;
        // d_ready_q is low throughout DRAIN, so a direct accept never meets a pop.
        w_direct = d_valid && d_ready_q;

        state_d = state_q;
        done_d  = 1'b0;

        // commit snapshots the occupancy after this cycle's push/pop.
        if (commit) begin
            remaining_d = w_count_next;
        end else if (w_pop) begin
            remaining_d = remaining_q - c_cnt_one;
        end else begin
            remaining_d = remaining_q;
        end

        // A commit while ARMED/DRAIN only reloads remaining; the state holds.
        unique case (state_q)
            IDLE: begin
                if (commit) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!commit && frame_end && !frame_start) begin
                    if (remaining_q != '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!commit) begin
                    if (frame_start) begin
                        state_d = ARMED;
                    end else if (remaining_q <= c_cnt_one) begin
                        // Last pop this cycle: done lines up with its bus write.
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        overflow_d = w_drop ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
        d_ready_d  = (state_d != DRAIN);

        bus_vld_d  = w_pop || w_direct;
        bus_addr_d = '0;
        bus_data_d = '0;
        if (w_pop) begin
            bus_addr_d = w_head[AW+DW-1:DW];
            bus_data_d = w_head[DW-1:0];
        end else if (w_direct) begin
            bus_addr_d = d_addr;
            bus_data_d = d_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            overflow_q  <= 1'b0;
            done_q      <= 1'b0;
            d_ready_q   <= 1'b0;
            bus_vld_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            overflow_q  <= overflow_d;
            done_q      <= done_d;
            d_ready_q   <= d_ready_d;
            bus_vld_q   <= bus_vld_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
        end
    end

    assign d_ready       = d_ready_q;
    assign video_cs      = bus_vld_q;
    assign video_wr      = bus_vld_q;
    assign video_addr    = bus_addr_q;
    assign video_wr_data = bus_data_q;
    assign q_count       = w_count;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign overflow      = overflow_q;

endmodule
`default_nettype wire
